// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The optional HAZARD_PERF_CNT_EN build adds a stall-cycle counter in hazard_ctrl.
package pipe_ctrl_pkg;

  localparam int MUL_CYCLES_DEF = 4;
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MUL_WAIT = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_FLUSH    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    MOP_HOLD,
    MOP_LOAD,
    MOP_DEC,
    MOP_SAT,
    MOP_CLR
  } mul_op_e;

endpackage

// File: rtl/mul_timer.sv
// Multiply occupancy countdown for the EXE stage.
// Load, plain decrement, saturating-at-1 decrement and clear.
module mul_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  localparam int CW = $clog2(MUL_CYCLES + 1)
) (
  input  logic    clk,
  input  logic    resetn,
  input  mul_op_e op_i,
  output logic    busy_o,
  output logic    last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  localparam logic [CW-1:0] ONE = CW'(1);

  always_comb begin
    cnt_d = cnt_q;
    unique case (op_i)
      MOP_LOAD: cnt_d = CW'(MUL_CYCLES - 1);
      MOP_DEC: begin
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
      end
      // Progress is tracked while stalled elsewhere, but the
      // final cycle is kept for the MUL_WAIT release.
      MOP_SAT: begin
        if (cnt_q > ONE) cnt_d = cnt_q - ONE;
      end
      MOP_CLR: cnt_d = '0;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);
  assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller: load-use, multiply, dcache miss, flush.
// Define HAZARD_PERF_CNT_EN to build the stall-cycle counter.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              id_valid,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              exe_valid,
  input  logic              exe_is_load,
  input  logic              exe_is_mul,
  input  logic [REG_AW-1:0] exe_wdest,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              if_miss,
  input  logic              flush_req,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_exe,
  output logic              stall_mem,
  output logic              bubble_id,
  output logic              bubble_exe,
  output logic              bubble_mem,
  output logic              bubble_wb,
  output logic              flush,
  output logic              mul_busy,
  output logic [2:0]        state_o,
  output logic [31:0]       perf_stall_cnt
);

  state_e  state_q;
  state_e  state_d;
  mul_op_e mul_op;
  logic    mul_act;
  logic    mul_last;

  logic s_if, s_id, s_exe, s_mem;
  logic b_id, b_exe, b_mem, b_wb;
  logic fl;

  logic dmiss;
  logic ld_use;
  logic mul_go;

  assign dmiss = mem_req && !mem_ack;

  assign ld_use = exe_valid && exe_is_load
    && (exe_wdest != '0) && id_valid
    && ((id_use_rs && id_rs == exe_wdest)
     || (id_use_rt && id_rt == exe_wdest));

  assign mul_go = exe_valid && exe_is_mul
    && !mul_act && (MUL_CYCLES > 1);

  mul_timer #(
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul_timer (
    .clk    (clk),
    .resetn (resetn),
    .op_i   (mul_op),
    .busy_o (mul_act),
    .last_o (mul_last)
  );

  always_comb begin
    state_d = state_q;
    mul_op  = MOP_HOLD;
    s_if  = 1'b0;
    s_id  = 1'b0;
    s_exe = 1'b0;
    s_mem = 1'b0;
    b_id  = 1'b0;
    b_exe = 1'b0;
    b_mem = 1'b0;
    b_wb  = 1'b0;
    fl    = 1'b0;
    unique case (state_q)
      ST_RUN, ST_MUL_WAIT: begin
        if (flush_req && dmiss) begin
          {s_if, s_id, s_exe, s_mem} = 4'hf;
          b_wb    = 1'b1;
          state_d = ST_DRAIN;
        end else if (flush_req) begin
          fl      = 1'b1;
          mul_op  = MOP_CLR;
          state_d = ST_FLUSH;
        end else if (dmiss) begin
          {s_if, s_id, s_exe, s_mem} = 4'hf;
          b_wb    = 1'b1;
          mul_op  = MOP_SAT;
          state_d = ST_MEM_WAIT;
        end else if (state_q == ST_MUL_WAIT) begin
          if (mul_act && !mul_last) begin
            {s_if, s_id, s_exe} = 3'h7;
            b_mem  = 1'b1;
            mul_op = MOP_DEC;
          end else begin
            mul_op  = MOP_CLR;
            state_d = ST_RUN;
          end
        end else if (mul_go) begin
          {s_if, s_id, s_exe} = 3'h7;
          b_mem   = 1'b1;
          mul_op  = MOP_LOAD;
          state_d = ST_MUL_WAIT;
        end else if (ld_use) begin
          s_if  = 1'b1;
          s_id  = 1'b1;
          b_exe = 1'b1;
        end else if (if_miss) begin
          s_if = 1'b1;
          b_id = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        mul_op = MOP_SAT;
        if (!mem_ack) begin
          {s_if, s_id, s_exe, s_mem} = 4'hf;
          b_wb = 1'b1;
        end else if (!mul_act) begin
          state_d = ST_RUN;
        end else begin
          {s_if, s_id, s_exe} = 3'h7;
          b_mem   = 1'b1;
          state_d = ST_MUL_WAIT;
        end
      end
      ST_DRAIN: begin
        if (!mem_ack) begin
          {s_if, s_id, s_exe, s_mem} = 4'hf;
          b_wb = 1'b1;
        end else begin
          fl      = 1'b1;
          mul_op  = MOP_CLR;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // Drops the fetch issued during the redirect cycle.
        b_id = 1'b1;
        if (flush_req) begin
          fl     = 1'b1;
          mul_op = MOP_CLR;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_RUN;
    else         state_q <= state_d;
  end

  assign stall_if   = resetn && s_if;
  assign stall_id   = resetn && s_id;
  assign stall_exe  = resetn && s_exe;
  assign stall_mem  = resetn && s_mem;
  assign bubble_id  = resetn && b_id;
  assign bubble_exe = resetn && b_exe;
  assign bubble_mem = resetn && b_mem;
  assign bubble_wb  = resetn && b_wb;
  assign flush      = resetn && fl;
  assign mul_busy   = resetn && mul_act;
  assign state_o    = resetn ? state_q : 3'd0;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       perf_q <= '0;
    else if (stall_if) perf_q <= perf_q + 32'd1;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MUL_CYCLES=4.
// Expected perf count follows HAZARD_PERF_CNT_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       id_valid, id_use_rs, id_use_rt;
  logic [4:0] id_rs, id_rt;
  logic       exe_valid, exe_is_load, exe_is_mul;
  logic [4:0] exe_wdest;
  logic       mem_req, mem_ack, if_miss, flush_req;
  logic       stall_if, stall_id, stall_exe, stall_mem;
  logic       bubble_id, bubble_exe, bubble_mem, bubble_wb;
  logic       flush, mul_busy;
  logic [2:0] state_o;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MUL_CYCLES(4),
    .REG_AW(5)
  ) dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_rs(id_rs), .id_rt(id_rt),
    .exe_valid(exe_valid), .exe_is_load(exe_is_load),
    .exe_is_mul(exe_is_mul), .exe_wdest(exe_wdest),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .if_miss(if_miss), .flush_req(flush_req),
    .stall_if(stall_if), .stall_id(stall_id),
    .stall_exe(stall_exe), .stall_mem(stall_mem),
    .bubble_id(bubble_id), .bubble_exe(bubble_exe),
    .bubble_mem(bubble_mem), .bubble_wb(bubble_wb),
    .flush(flush), .mul_busy(mul_busy),
    .state_o(state_o),
    .perf_stall_cnt(perf_stall_cnt)
  );

  localparam logic [12:0] SIF  = 13'h1000;
  localparam logic [12:0] SID  = 13'h0800;
  localparam logic [12:0] SEXE = 13'h0400;
  localparam logic [12:0] SMEM = 13'h0200;
  localparam logic [12:0] BID  = 13'h0100;
  localparam logic [12:0] BEXE = 13'h0080;
  localparam logic [12:0] BMEM = 13'h0040;
  localparam logic [12:0] BWB  = 13'h0020;
  localparam logic [12:0] FL   = 13'h0010;
  localparam logic [12:0] BUSY = 13'h0008;
  localparam logic [12:0] S_MUL = 13'd1;
  localparam logic [12:0] S_MEM = 13'd2;
  localparam logic [12:0] S_DRN = 13'd3;
  localparam logic [12:0] S_FLS = 13'd4;
  localparam logic [12:0] ALL4 = SIF | SID | SEXE | SMEM;
  localparam logic [12:0] MULS = SIF | SID | SEXE | BMEM;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [31:0] PERF_EXP = 32'd4;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  typedef struct packed {
    logic       rn;
    logic       ev, ld, ml;
    logic [4:0] wd;
    logic       iv, urs;
    logic [4:0] rs;
    logic       urt;
    logic [4:0] rt;
    logic       mr, ma, im, fr;
  } stim_t;

  int checks = 0;
  int failures = 0;
  logic [12:0] sb_q[$];

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stim_t st(
    bit rn = 1, bit ev = 0, bit ld = 0, bit ml = 0,
    logic [4:0] wd = 0, bit iv = 0, bit urs = 0,
    logic [4:0] rs = 0, bit urt = 0, logic [4:0] rt = 0,
    bit mr = 0, bit ma = 0, bit im = 0, bit fr = 0);
    stim_t s;
    s.rn = rn; s.ev = ev; s.ld = ld; s.ml = ml;
    s.wd = wd; s.iv = iv; s.urs = urs; s.rs = rs;
    s.urt = urt; s.rt = rt; s.mr = mr; s.ma = ma;
    s.im = im; s.fr = fr;
    return s;
  endfunction

  task automatic apply(stim_t s);
    resetn      = s.rn;
    exe_valid   = s.ev;
    exe_is_load = s.ld;
    exe_is_mul  = s.ml;
    exe_wdest   = s.wd;
    id_valid    = s.iv;
    id_use_rs   = s.urs;
    id_rs       = s.rs;
    id_use_rt   = s.urt;
    id_rt       = s.rt;
    mem_req     = s.mr;
    mem_ack     = s.ma;
    if_miss     = s.im;
    flush_req   = s.fr;
  endtask

  task automatic step(string tag, stim_t s,
                      logic [12:0] e);
    logic [12:0] obs;
    @(negedge clk);
    apply(s);
    sb_q.push_back(e);
    #1;
    obs = {stall_if, stall_id, stall_exe, stall_mem,
           bubble_id, bubble_exe, bubble_mem, bubble_wb,
           flush, mul_busy, state_o};
    check(tag, {19'd0, obs}, {19'd0, sb_q.pop_front()});
  endtask

  initial begin
    apply(st(.rn(0)));
    step("rst_hold", st(.rn(0), .ev(1), .ml(1), .mr(1),
         .fr(1), .im(1)), 13'd0);
    check("rst_perf", perf_stall_cnt, 32'd0);
    step("idle", st(), 13'd0);
    step("ack_noreq", st(.ma(1)), 13'd0);

    step("lu_rs", st(.ev(1), .ld(1), .wd(5), .iv(1),
         .urs(1), .rs(5)), SIF | SID | BEXE);
    step("lu_after", st(), 13'd0);
    step("lu_wd0", st(.ev(1), .ld(1), .wd(0), .iv(1),
         .urs(1), .rs(0)), 13'd0);
    step("lu_rt", st(.ev(1), .ld(1), .wd(7), .iv(1),
         .urt(1), .rt(7)), SIF | SID | BEXE);
    step("lu_nouse", st(.ev(1), .ld(1), .wd(5), .iv(1),
         .rs(5)), 13'd0);
    step("ifmiss", st(.im(1)), SIF | BID);

    step("mul_c0", st(.ev(1), .ml(1)), MULS);
    step("mul_c1", st(.ev(1), .ml(1)), MULS | BUSY | S_MUL);
    step("mul_c2", st(.ev(1), .ml(1)), MULS | BUSY | S_MUL);
    step("mul_c3", st(.ev(1), .ml(1)), BUSY | S_MUL);
    step("mul_c4", st(), 13'd0);

    step("md_c0", st(.ev(1), .ml(1)), MULS);
    step("md_c1", st(.ev(1), .ml(1), .mr(1)),
         ALL4 | BWB | BUSY | S_MUL);
    step("md_c2", st(.ev(1), .ml(1), .mr(1)),
         ALL4 | BWB | BUSY | S_MEM);
    step("md_c3", st(.ev(1), .ml(1), .mr(1)),
         ALL4 | BWB | BUSY | S_MEM);
    step("md_ack", st(.ev(1), .ml(1), .mr(1), .ma(1)),
         MULS | BUSY | S_MEM);
    step("md_rel", st(.ev(1), .ml(1)), BUSY | S_MUL);
    step("md_run", st(), 13'd0);

    step("dr_c0", st(.fr(1), .mr(1)), ALL4 | BWB);
    step("dr_c1", st(.mr(1)), ALL4 | BWB | S_DRN);
    step("dr_ack", st(.mr(1), .ma(1)), FL | S_DRN);
    step("dr_fls", st(), BID | S_FLS);
    step("dr_run", st(), 13'd0);

    step("fl_c0", st(.fr(1)), FL);
    step("fl_again", st(.fr(1)), FL | BID | S_FLS);
    step("fl_c2", st(), BID | S_FLS);
    step("fl_run", st(), 13'd0);

    step("mf_c0", st(.ev(1), .ml(1)), MULS);
    step("mf_fl", st(.ev(1), .ml(1), .fr(1)),
         FL | BUSY | S_MUL);
    step("mf_fls", st(), BID | S_FLS);
    step("mf_run", st(), 13'd0);

    step("mr_c0", st(.ev(1), .ml(1)), MULS);
    step("mr_c1", st(.ev(1), .ml(1)), MULS | BUSY | S_MUL);
    step("mr_rst", st(.rn(0), .ev(1), .ml(1)), 13'd0);
    step("mr_post", st(), 13'd0);

    step("pf_rst", st(.rn(0)), 13'd0);
    step("pf_m0", st(.mr(1)), ALL4 | BWB);
    step("pf_m1", st(.mr(1)), ALL4 | BWB | S_MEM);
    step("pf_m2", st(.mr(1)), ALL4 | BWB | S_MEM);
    step("pf_ack", st(.mr(1), .ma(1)), S_MEM);
    step("pf_lu", st(.ev(1), .ld(1), .wd(9), .iv(1),
         .urs(1), .rs(9)), SIF | SID | BEXE);
    step("pf_idle", st(), 13'd0);
    check("perf_cnt", perf_stall_cnt, PERF_EXP);

    check("sb_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS core (IF/ID/EXE/MEM/WB). It complements the operand forwarding unit by handling what forwarding cannot: load-use hazards, multi-cycle multiply occupancy in EXE, data-cache miss stalls and exception/eret flushes. It produces per-stage hold and bubble controls for the PC and the four pipeline registers.

## Interface
- MUL_CYCLES, 4, number of cycles a multiply occupies EXE; legal range ≥1.
- REG_AW, 5, register address width.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- id_valid, id_use_rs, id_use_rt  in  1 each  ID holds a valid instr; it reads rs / rt.
- id_rs, id_rt  in  REG_AW  ID source registers.
- exe_valid, exe_is_load, exe_is_mul  in  1 each  EXE instr is valid / is a load / is mult(u).
- exe_wdest  in  REG_AW  EXE destination register.
- mem_req  in  1  MEM stage has a dcache access this cycle.
- mem_ack  in  1  dcache has completed that access.
- if_miss  in  1  icache not ready this cycle.
- flush_req  in  1  WB raises exception/eret redirect.
- stall_if, stall_id, stall_exe, stall_mem  out  1 each  hold PC, IF/ID, ID/EXE, EXE/MEM.
- bubble_id, bubble_exe, bubble_mem, bubble_wb  out  1 each  load NOP into IF/ID, ID/EXE, EXE/MEM, MEM/WB.
- flush  out  1  clear valid bits of IF/ID, ID/EXE and EXE/MEM.
- mul_busy  out  1  multiply countdown active.
- state_o  out  3  current FSM state.
- perf_stall_cnt  out  32  stall-cycle counter (see Configuration).

## Operation
- States: RUN, MUL_WAIT, MEM_WAIT, DRAIN, FLUSH. Internal mul_cnt of width $clog2(MUL_CYCLES+1).
- Outputs are combinational from state, mul_cnt and inputs. Signals not listed in a case are 0.
- RUN priority (highest first):
  - flush_req && mem_req && !mem_ack: all four stalls asserted, bubble_wb; next state DRAIN.
  - flush_req: flush asserted; mul_cnt←0; next state FLUSH.
  - mem_req && !mem_ack (dmiss): stall_if/id/exe/mem and bubble_wb asserted; next state MEM_WAIT.
  - exe_valid && exe_is_mul && mul_cnt==0 && MUL_CYCLES>1: stall_if/id/exe and bubble_mem asserted; mul_cnt←MUL_CYCLES-1; next state MUL_WAIT.
  - load-use: exe_valid && exe_is_load && exe_wdest!=0 && id_valid && ((id_use_rs && id_rs==exe_wdest) || (id_use_rt && id_rt==exe_wdest)). Asserts stall_if, stall_id, bubble_exe for one cycle. No state change.
  - if_miss: stall_if and bubble_id asserted. Back end proceeds.
- MUL_WAIT:
  - mul_cnt>1: stall_if/id/exe and bubble_mem asserted; mul_cnt decrements.
  - mul_cnt==1: release; mul_cnt←0; next state RUN.
  - dmiss in MUL_WAIT: next state MEM_WAIT, same outputs as the dmiss case in RUN. mul_cnt keeps decrementing, saturating at 1.
  - flush_req in MUL_WAIT: handled exactly as in RUN.
- MEM_WAIT:
  - While !mem_ack: all four stalls and bubble_wb asserted; mul_cnt saturating decrement.
  - On mem_ack with mul_cnt==0: stalls released; next state RUN.
  - On mem_ack with mul_cnt!=0: stall_if/id/exe and bubble_mem asserted; next state MUL_WAIT.
- DRAIN: all four stalls and bubble_wb asserted until mem_ack. On the mem_ack cycle: flush asserted; mul_cnt←0; next state FLUSH.
- FLUSH: one cycle with bubble_id asserted, which discards the fetch issued in the redirect cycle; next state RUN. A new flush_req here asserts flush again and the FSM stays in FLUSH.
- mul_busy = (mul_cnt!=0).
- state_o encoding: RUN=0, MUL_WAIT=1, MEM_WAIT=2, DRAIN=3, FLUSH=4.

## Timing
- Detection-to-stall latency is zero (same cycle). The state takes effect next edge.
- A multiply occupies EXE for exactly MUL_CYCLES cycles and advances at the end of the last one. With MUL_CYCLES=1 there is no stall.
- A load-use hazard costs exactly one bubble; the MEM-stage forward path then supplies the operand.
- mem_req/mem_ack: the access completes in the cycle mem_ack=1. mem_ack without mem_req is ignored in RUN.
- While resetn=0: state=RUN, mul_cnt=0, perf_stall_cnt=0, and every output is forced to 0.
- Reset asserted mid-MUL_WAIT, MEM_WAIT or DRAIN aborts the operation immediately.

## Configuration
- HAZARD_PERF_CNT_EN defined: perf_stall_cnt increments (wrapping at 2^32) on every cycle stall_if=1.
- HAZARD_PERF_CNT_EN undefined: perf_stall_cnt is tied to 0 and no counter is built.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state enum and its encoding;
  - the MUL_CYCLES default;
  - the REG_AW constant.
- Sub-module mul_timer: mul_cnt load, decrement, saturate and clear, with a busy/last output.

## Test plan
- Load-use: exe_is_load, exe_wdest=5, id_rs=5, id_use_rs=1 -> stall_if=stall_id=bubble_exe=1 for one cycle. Same stimulus with exe_wdest=0 -> all 0.
- Multiply, MUL_CYCLES=4: exe_is_mul at cycle 0 -> stall_exe=1 in cycles 0–2, 0 in cycle 3; mul_busy=1 in cycles 1–3; state_o back to RUN at cycle 4.
- mem_req issued in the cycle after a multiply starts (cycle 1), with mem_ack 3 cycles later -> MEM_WAIT with mul_cnt decrementing, saturating at 1; on the mem_ack cycle stall_mem=0 and bubble_mem=1; next state MUL_WAIT, which releases in one cycle.
- flush_req together with mem_req && !mem_ack, then mem_ack 2 cycles later -> DRAIN for 2 cycles; flush=1 on the ack cycle only; FLUSH with bubble_id=1; then RUN.
- resetn low during MUL_WAIT with mul_cnt=2 -> all outputs 0 immediately; after release state_o=0 and mul_busy=0.
- With HAZARD_PERF_CNT_EN: 3-cycle dmiss plus one load-use -> perf_stall_cnt=4. Without the macro -> perf_stall_cnt stays 0.
